// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding selects, load-use stall detection and a
// per-register scoreboard of in-flight long-latency (mult/div) writes.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   id_valid/id_rs/id_rt/*_used     ID stage sources
//   ex_rs/ex_rt/ex_dest             ID/EX registers
//   ex_reg_write/ex_mem_read        ID/EX control
//   mem_dest/mem_reg_write          EX/MEM writer
//   wb_dest/wb_reg_write            MEM/WB writer
//   long_issue/long_dest            long op in ID and its destination
//   flush                           squash the ID instruction
//   fwd_a/fwd_b                     EX operand select (00 rf, 01 EX/MEM, 10 MEM/WB)
//   id_fwd_a/id_fwd_b               ID operand takes MEM/WB value
//   stall                           freeze PC/IF-ID, bubble ID/EX
//   busy_vec                        scoreboard busy bit per register
//
// Optional macro HAZARD_PERF_CNT_EN adds stall_cycles / load_use_cycles.

// One scoreboard entry: busy flag plus countdown to forwardable result.
module hazard_sb_entry #(
  parameter int CNT_W    = 4,
  parameter int LONG_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  output logic busy
);
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (set) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(LONG_LAT);
    end else if (busy_q) begin
      if (cnt_q > CNT_W'(1)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;
endmodule

module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32,
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [REG_AW-1:0]   ex_rs,
  input  logic [REG_AW-1:0]   ex_rt,
  input  logic [REG_AW-1:0]   ex_dest,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic [REG_AW-1:0]   mem_dest,
  input  logic                mem_reg_write,
  input  logic [REG_AW-1:0]   wb_dest,
  input  logic                wb_reg_write,
  input  logic                long_issue,
  input  logic [REG_AW-1:0]   long_dest,
  input  logic                flush,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                id_fwd_a,
  output logic                id_fwd_b,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         load_use_cycles
`endif
);
  logic [NUM_REGS-1:0] busy;
  logic                mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic                load_use, sb_haz, issue, lu_stall;

  // ex_reg_write describes the ID/EX instruction itself; forwarding only
  // looks at later stages, so it has no consumer here.
  logic                unused_ok;
  assign unused_ok = ex_reg_write;

  // EX-stage forwarding: EX/MEM beats MEM/WB, r0 never matches.
  assign mem_hit_a = mem_reg_write && (mem_dest != '0) && (mem_dest == ex_rs);
  assign mem_hit_b = mem_reg_write && (mem_dest != '0) && (mem_dest == ex_rt);
  assign wb_hit_a  = wb_reg_write  && (wb_dest  != '0) && (wb_dest  == ex_rs);
  assign wb_hit_b  = wb_reg_write  && (wb_dest  != '0) && (wb_dest  == ex_rt);

  assign fwd_a = mem_hit_a ? 2'b01 : (wb_hit_a ? 2'b10 : 2'b00);
  assign fwd_b = mem_hit_b ? 2'b01 : (wb_hit_b ? 2'b10 : 2'b00);

  assign id_fwd_a = wb_reg_write && (wb_dest != '0) && (wb_dest == id_rs);
  assign id_fwd_b = wb_reg_write && (wb_dest != '0) && (wb_dest == id_rt);

  assign load_use = ex_mem_read && (ex_dest != '0) &&
                    ((id_rs_used && (ex_dest == id_rs)) ||
                     (id_rt_used && (ex_dest == id_rt)));

  // Last term is WAW: a new long op may not retarget a still-busy register.
  assign sb_haz = (id_rs_used && busy[id_rs]) ||
                  (id_rt_used && busy[id_rt]) ||
                  (long_issue && (long_dest != '0) && busy[long_dest]);

  // rst_n gating keeps stall low while reset is held, independent of inputs.
  assign stall    = rst_n && id_valid && !flush && (load_use || sb_haz);
  assign lu_stall = rst_n && id_valid && !flush && load_use;
  assign issue    = id_valid && long_issue && !stall && !flush && (long_dest != '0);

  assign busy[0] = 1'b0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
    localparam logic [REG_AW-1:0] IDX = REG_AW'(r);
    hazard_sb_entry #(.CNT_W(CNT_W), .LONG_LAT(LONG_LAT)) u_ent (
      .clk  (clk),
      .rst_n(rst_n),
      .set  (issue && (long_dest == IDX)),
      .busy (busy[r])
    );
  end

  assign busy_vec = busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] load_use_cycles_q, load_use_cycles_d;

  always_comb begin
    stall_cycles_d    = stall_cycles_q + {31'd0, stall};
    load_use_cycles_d = load_use_cycles_q + {31'd0, lu_stall};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q    <= '0;
      load_use_cycles_q <= '0;
    end else begin
      stall_cycles_q    <= stall_cycles_d;
      load_use_cycles_q <= load_use_cycles_d;
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign load_use_cycles = load_use_cycles_q;
`else
  logic unused_lu;
  assign unused_lu = lu_stall;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked
// against a behavioural model (remaining-busy-cycles per register).
module tb_hazard_scoreboard;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int LL = 4;

  logic          clk, rst_n;
  logic          id_valid, id_rs_used, id_rt_used;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest, long_dest;
  logic          ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write, long_issue, flush;
  logic [1:0]    fwd_a, fwd_b;
  logic          id_fwd_a, id_fwd_b, stall;
  logic [NR-1:0] busy_vec;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   stall_cycles, load_use_cycles;
`endif

  hazard_scoreboard #(.REG_AW(AW), .NUM_REGS(NR), .LONG_LAT(LL), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_dest(mem_dest), .mem_reg_write(mem_reg_write),
    .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
    .long_issue(long_issue), .long_dest(long_dest), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b),
    .stall(stall), .busy_vec(busy_vec)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .load_use_cycles(load_use_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rem [NR];   // cycles a register still reads as busy

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
    if (mem_reg_write && mem_dest != 0 && mem_dest == src) return 2'b01;
    if (wb_reg_write && wb_dest != 0 && wb_dest == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic m_idfwd(input logic [AW-1:0] src);
    return wb_reg_write && wb_dest != 0 && wb_dest == src;
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] r);
    return (r != 0) && (rem[r] > 0);
  endfunction

  function automatic logic m_stall();
    logic lu, sb;
    lu = ex_mem_read && ex_dest != 0 &&
         ((id_rs_used && ex_dest == id_rs) || (id_rt_used && ex_dest == id_rt));
    sb = (id_rs_used && m_busy(id_rs)) || (id_rt_used && m_busy(id_rt)) ||
         (long_issue && long_dest != 0 && m_busy(long_dest));
    return rst_n && id_valid && !flush && (lu || sb);
  endfunction

  function automatic logic [NR-1:0] m_bvec();
    logic [NR-1:0] v;
    v = '0;
    for (int r = 1; r < NR; r++) v[r] = rem[r] > 0;
    return v;
  endfunction

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    ex_rs = 0; ex_rt = 0; ex_dest = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_dest = 0; mem_reg_write = 0; wb_dest = 0; wb_reg_write = 0;
    long_issue = 0; long_dest = 0; flush = 0;
  endtask

  // Check all outputs against the model, then advance one clock.
  task automatic tick();
    logic issue;
    #2;
    chk("fwd_a", fwd_a, m_fwd(ex_rs));
    chk("fwd_b", fwd_b, m_fwd(ex_rt));
    chk("id_fwd_a", id_fwd_a, m_idfwd(id_rs));
    chk("id_fwd_b", id_fwd_b, m_idfwd(id_rt));
    chk("stall", stall, m_stall());
    chk("busy_vec", busy_vec, m_bvec());
    issue = id_valid && long_issue && !m_stall() && !flush && long_dest != 0;
    @(posedge clk);
    for (int r = 1; r < NR; r++) begin
      if (issue && long_dest == r) rem[r] = LL;
      else if (rem[r] > 0) rem[r]--;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < NR; r++) rem[r] = 0;
    idle();
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", busy_vec, '0);
    chk("rst_stall", stall, 0);
    rst_n = 1;
    @(negedge clk);

    // Forwarding priority
    mem_dest = 5; wb_dest = 5; ex_rs = 5; mem_reg_write = 1; wb_reg_write = 1;
    #1 chk("fwd_pri_mem", fwd_a, 2'b01);
    tick();
    mem_reg_write = 0;
    #1 chk("fwd_pri_wb", fwd_a, 2'b10);
    tick();
    mem_reg_write = 1; ex_rs = 0; mem_dest = 0; wb_dest = 0;
    #1 chk("fwd_r0", fwd_a, 2'b00);
    tick();
    idle();

    // Load-use: three stalled cycles, then source not read
    ex_mem_read = 1; ex_dest = 8; id_rt = 8; id_rt_used = 1; id_valid = 1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("lu_stall", stall, 1);
      tick();
    end
    id_rt_used = 0;
    #1 chk("lu_unused", stall, 0);
    tick();
    idle();

    // Scoreboard: issue to r9, consumer waits LONG_LAT cycles
    id_valid = 1; long_issue = 1; long_dest = 9;
    tick();
    long_issue = 0; long_dest = 0; id_rs = 9; id_rs_used = 1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk("sb_busy9", busy_vec[9], c <= 4);
      chk("sb_stall", stall, c <= 4);
      tick();
    end
    idle();

`ifdef HAZARD_PERF_CNT_EN
    chk("perf_lu", load_use_cycles, 3);
    chk("perf_stall", stall_cycles, 7);
`endif

    // WAW and concurrency
    id_valid = 1; long_issue = 1; long_dest = 3;
    tick();
    long_dest = 4;
    tick();
    long_dest = 3;
    for (int c = 2; c <= 5; c++) begin
      #1 chk("waw_stall", stall, c <= 4);
      tick();
    end
    idle();
    #1 chk("waw_busy3", busy_vec[3], 1);
    chk("waw_busy4_clr", busy_vec[4], 0);
    for (int c = 0; c < 6; c++) tick();

    // Flush hides the hazard and creates no entry
    id_valid = 1; long_issue = 1; long_dest = 7;
    tick();
    long_dest = 7; id_rs = 7; id_rs_used = 1; flush = 1;
    #1 chk("flush_stall", stall, 0);
    tick();
    flush = 0; long_issue = 0; long_dest = 12; id_rs_used = 0;
    long_issue = 1; flush = 1;
    tick();
    idle();
    #1 chk("flush_noent", busy_vec[12], 0);
    for (int c = 0; c < 5; c++) tick();

    // Reset mid-countdown
    id_valid = 1; long_issue = 1; long_dest = 6;
    tick();
    idle();
    tick();
    rst_n = 0;
    #1;
    chk("rst_mid_busy", busy_vec, '0);
    chk("rst_mid_stall", stall, 0);
    for (int r = 0; r < NR; r++) rem[r] = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      id_valid      = $urandom_range(0, 3) != 0;
      id_rs         = AW'($urandom_range(0, 7));
      id_rt         = AW'($urandom_range(0, 7));
      id_rs_used    = $urandom_range(0, 1);
      id_rt_used    = $urandom_range(0, 1);
      ex_rs         = AW'($urandom_range(0, 7));
      ex_rt         = AW'($urandom_range(0, 7));
      ex_dest       = AW'($urandom_range(0, 7));
      ex_reg_write  = $urandom_range(0, 1);
      ex_mem_read   = $urandom_range(0, 3) == 0;
      mem_dest      = AW'($urandom_range(0, 7));
      mem_reg_write = $urandom_range(0, 1);
      wb_dest       = AW'($urandom_range(0, 7));
      wb_reg_write  = $urandom_range(0, 1);
      long_issue    = $urandom_range(0, 2) == 0;
      long_dest     = AW'($urandom_range(0, 7));
      flush         = $urandom_range(0, 9) == 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
